// File: rtl/bcd_addsub_serial.sv
// bcd_addsub_serial: digit-serial BCD adder/subtractor with valid/ready operand and result handshakes
module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);
  localparam int W = 4 * DIGITS;
  localparam int KW = $clog2(DIGITS + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d, oa, ob;
  logic c_q, c_d, sub_q, sub_d, err_q, err_d, cout_q, cout_d, eo_q, eo_d, bad, last;
  logic [3:0] bk, rk;
  logic [4:0] d;
  assign in_ready = state_q == IDLE && !rst;
  assign out_valid = state_q == DONE;
  assign sum = sum_q;
  assign cout = cout_q;
  assign err = eo_q;
  always_comb begin
    oa = a;
    ob = b;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (oa[3:0] > 4'd9) | (ob[3:0] > 4'd9);
      oa = oa >> 4;
      ob = ob >> 4;
    end
  end
  always_comb begin
    bk = sub_q ? 4'd9 - b_q[3:0] : b_q[3:0];
    d = {1'b0, a_q[3:0]} + {1'b0, bk} + {4'd0, c_q};
    rk = d > 5'd9 ? d[3:0] + 4'd6 : d[3:0];
    last = k_q == KW'(DIGITS - 1);
    state_d = state_q;
    k_d = k_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    sum_d = sum_q;
    c_d = c_q;
    sub_d = sub_q;
    err_d = err_q;
    cout_d = cout_q;
    eo_d = eo_q;
    if (state_q == IDLE && in_valid) begin
      a_d = a;
      b_d = b;
      c_d = cin;
      sub_d = sub;
      err_d = bad;
      k_d = '0;
      res_d = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      a_d = a_q >> 4;
      b_d = b_q >> 4;
      c_d = d > 5'd9;
      res_d = (res_q >> 4) | (W'(rk) << (W - 4));
      k_d = k_q + 1'b1;
      state_d = last ? DONE : RUN;
      sum_d = last ? res_d : sum_q;
      cout_d = last ? c_d : cout_q;
      eo_d = last ? err_q : eo_q;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      sum_q <= '0;
      c_q <= 1'b0;
      sub_q <= 1'b0;
      err_q <= 1'b0;
      cout_q <= 1'b0;
      eo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      sum_q <= sum_d;
      c_q <= c_d;
      sub_q <= sub_d;
      err_q <= err_d;
      cout_q <= cout_d;
      eo_q <= eo_d;
    end
  end
endmodule
